// File: rtl/bus_master_if.sv
// Master-side bridge from a single-outstanding core request port to one master
// slot of the shared bus: request/grant, address phase, slave ready, timeout abort.
module bus_master_if #(
  parameter int TIMEOUT = 256,
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32
) (
  input  logic              bus_clk,
  input  logic              bus_rstn,
  input  logic              core_req,
  input  logic              core_rw,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_busy,
  output logic              core_ack,
  output logic              core_err,
  output logic [DATA_W-1:0] core_rdata,
  output logic              m_reqn,
  input  logic              m_grntn,
  output logic              m_asn,
  output logic              m_rw,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_rdy
);

  localparam int              CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit              TO_EN    = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, REQ, ACCESS, DONE} state_t;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t             state, state_d;
  req_t               hold, hold_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               reqn_d, asn_d, rw_d, busy_d, ack_d, err_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [DATA_W-1:0]  wdata_d, rdata_d;
  logic               to_hit;

  assign to_hit = TO_EN && (cnt == CNT_LAST);

  always_comb begin
    state_d = state;
    hold_d  = hold;
    cnt_d   = cnt;
    reqn_d  = m_reqn;
    asn_d   = m_asn;
    rw_d    = m_rw;
    addr_d  = m_addr;
    wdata_d = m_wdata;
    busy_d  = core_busy;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = core_rdata;
    // Counter only runs while the bus is being requested or accessed.
    if ((state == REQ || state == ACCESS) && cnt != '1) cnt_d = cnt + 1'b1;
    case (state)
      IDLE: if (core_req) begin
        state_d = REQ;
        hold_d  = '{rw: core_rw, addr: core_addr, wdata: core_wdata};
        cnt_d   = '0;
        reqn_d  = 1'b0;
        busy_d  = 1'b1;
      end
      REQ: begin
        if (to_hit) begin
          state_d = DONE;
          ack_d   = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
        end else if (!m_grntn) begin
          state_d = ACCESS;
          asn_d   = 1'b0;
          rw_d    = hold.rw;
          addr_d  = hold.addr;
          wdata_d = hold.rw ? '0 : hold.wdata;
        end
      end
      ACCESS: begin
        // A ready in the last allowed cycle beats both timeout and grant loss.
        if (m_rdy) begin
          state_d = DONE;
          ack_d   = 1'b1;
          if (hold.rw) rdata_d = m_rdata;
        end else if (to_hit || m_grntn) begin
          state_d = DONE;
          ack_d   = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == DONE && state != DONE) begin
      reqn_d  = 1'b1;
      asn_d   = 1'b1;
      rw_d    = 1'b1;
      addr_d  = '0;
      wdata_d = '0;
    end
  end

  always_ff @(posedge bus_clk or negedge bus_rstn) begin
    if (!bus_rstn) begin
      state      <= IDLE;
      hold       <= '0;
      cnt        <= '0;
      m_reqn     <= 1'b1;
      m_asn      <= 1'b1;
      m_rw       <= 1'b1;
      m_addr     <= '0;
      m_wdata    <= '0;
      core_busy  <= 1'b0;
      core_ack   <= 1'b0;
      core_err   <= 1'b0;
      core_rdata <= '0;
    end else begin
      state      <= state_d;
      hold       <= hold_d;
      cnt        <= cnt_d;
      m_reqn     <= reqn_d;
      m_asn      <= asn_d;
      m_rw       <= rw_d;
      m_addr     <= addr_d;
      m_wdata    <= wdata_d;
      core_busy  <= busy_d;
      core_ack   <= ack_d;
      core_err   <= err_d;
      core_rdata <= rdata_d;
    end
  end

endmodule

// File: tb/tb_bus_master_if.sv
// Bench for bus_master_if: default-timeout instance for normal traffic and a
// TIMEOUT=8 instance for timeout corners; acks checked against a scoreboard.
module tb_bus_master_if;
  logic        bus_clk = 1'b0;
  logic        bus_rstn = 1'b0;
  logic        core_req = 1'b0, core_req_b = 1'b0, core_rw = 1'b1;
  logic [29:0] core_addr = '0;
  logic [31:0] core_wdata = '0;
  logic        m_grntn = 1'b1, m_grntn_b = 1'b1, m_rdy = 1'b0;
  logic [31:0] m_rdata = '0;

  logic        core_busy, core_ack, core_err, m_reqn, m_asn, m_rw;
  logic [31:0] core_rdata, m_wdata;
  logic [29:0] m_addr;
  logic        busy_b, ack_b, err_b, reqn_b, asn_b, rw_b;
  logic [31:0] rdata_b, wdata_b;
  logic [29:0] addr_b;

  int checks = 0, errors = 0, ack_cnt = 0, base;
  logic [32:0] q_a[$], q_b[$];

  always #5 bus_clk = ~bus_clk;

  bus_master_if dut (
    .bus_clk(bus_clk), .bus_rstn(bus_rstn), .core_req(core_req), .core_rw(core_rw),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_busy(core_busy),
    .core_ack(core_ack), .core_err(core_err), .core_rdata(core_rdata),
    .m_reqn(m_reqn), .m_grntn(m_grntn), .m_asn(m_asn), .m_rw(m_rw), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_rdy(m_rdy));

  bus_master_if #(.TIMEOUT(8)) dut_to (
    .bus_clk(bus_clk), .bus_rstn(bus_rstn), .core_req(core_req_b), .core_rw(core_rw),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_busy(busy_b),
    .core_ack(ack_b), .core_err(err_b), .core_rdata(rdata_b),
    .m_reqn(reqn_b), .m_grntn(m_grntn_b), .m_asn(asn_b), .m_rw(rw_b), .m_addr(addr_b),
    .m_wdata(wdata_b), .m_rdata(m_rdata), .m_rdy(m_rdy));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge bus_clk); #1;
  endtask

  // Scoreboards: every ack pops the oldest expected {err, rdata}.
  always begin
    @(posedge bus_clk); #1;
    if (core_ack === 1'b1) begin
      ack_cnt++;
      if (q_a.size() == 0) chk("a_unexpected_ack", 1, 0);
      else chk("a_ack_data", {core_err, core_rdata}, q_a.pop_front());
    end
    if (ack_b === 1'b1) begin
      if (q_b.size() == 0) chk("b_unexpected_ack", 1, 0);
      else chk("b_ack_data", {err_b, rdata_b}, q_b.pop_front());
    end
  end

  // Arbiter/slave stand-in for dut: grant once requested, ready after ws waits.
  task automatic serve(input logic [31:0] rd, input int ws);
    int n = 0;
    while (m_reqn !== 1'b0 && n < 20) begin tick(); n++; end
    chk("serve_reqn", m_reqn, 0);
    m_grntn = 1'b0; tick();
    chk("serve_asn", m_asn, 0);
    repeat (ws) tick();
    m_rdy = 1'b1; m_rdata = rd; tick();
    m_rdy = 1'b0; m_grntn = 1'b1;
  endtask

  task automatic to_run(input bit rdy_last);
    core_req_b = 1'b1; core_rw = 1'b1; core_addr = 30'h40;
    if (rdy_last) q_b.push_back({1'b0, 32'h55AA_55AA}); else q_b.push_back({1'b1, 32'h0});
    tick();
    chk("to_reqn_entry", reqn_b, 0);
    core_req_b = 1'b0; m_grntn_b = 1'b0; tick();
    chk("to_asn", asn_b, 0);
    for (int i = 2; i < 8; i++) begin chk("to_no_ack", ack_b, 0); tick(); end
    chk("to_no_ack_last", ack_b, 0);
    if (rdy_last) begin m_rdy = 1'b1; m_rdata = 32'h55AA_55AA; end
    tick();
    m_rdy = 1'b0; m_grntn_b = 1'b1;
    chk("to_ack", ack_b, 1);
    chk("to_reqn_rel", reqn_b, 1);
    chk("to_asn_rel", asn_b, 1);
    tick();
    chk("to_idle_busy", busy_b, 0);
  endtask

  initial begin
    tick(); tick();
    chk("rst_vals", {m_reqn, m_asn, m_rw, core_busy, core_ack, core_err}, 6'b111000);
    chk("rst_addr", m_addr, 0);
    chk("rst_wdata", m_wdata, 0);
    chk("rst_rdata", core_rdata, 0);
    #2 bus_rstn = 1'b1;
    tick();

    // Zero-wait read, one-cycle grant.
    core_req = 1'b1; core_rw = 1'b1; core_addr = 30'h100;
    q_a.push_back({1'b0, 32'hDEAD_BEEF});
    tick();
    core_req = 1'b0;
    chk("rd_reqn_c1", m_reqn, 0);
    chk("rd_busy_c1", core_busy, 1);
    chk("rd_asn_c1", m_asn, 1);
    tick();
    chk("rd_asn_c2", m_asn, 1);
    m_grntn = 1'b0; tick();
    chk("rd_asn_c3", m_asn, 0);
    chk("rd_addr_c3", m_addr, 30'h100);
    chk("rd_wdata_c3", m_wdata, 0);
    m_rdy = 1'b1; m_rdata = 32'hDEAD_BEEF; tick();
    m_rdy = 1'b0; m_grntn = 1'b1;
    chk("rd_ack_c4", core_ack, 1);
    chk("rd_rel_c4", {m_reqn, m_asn}, 2'b11);
    tick();
    chk("rd_idle_c5", {core_busy, core_ack}, 2'b00);

    // Write with three wait states; read data must stay untouched.
    core_req = 1'b1; core_rw = 1'b0; core_addr = 30'h2A; core_wdata = 32'h1234_5678;
    q_a.push_back({1'b0, 32'hDEAD_BEEF});
    tick();
    core_req = 1'b0; core_wdata = 32'hFFFF_FFFF; m_grntn = 1'b0; tick();
    for (int i = 0; i < 4; i++) begin
      chk("wr_asn", m_asn, 0);
      chk("wr_fields", {m_rw, m_addr, m_wdata}, {1'b0, 30'h2A, 32'h1234_5678});
      chk("wr_no_ack", core_ack, 0);
      if (i == 3) m_rdy = 1'b1;
      tick();
    end
    m_rdy = 1'b0; m_grntn = 1'b1;
    chk("wr_ack", core_ack, 1);
    tick();

    // Grant held off for 10 cycles while foreign traffic toggles ready/data.
    core_req = 1'b1; core_rw = 1'b1; core_addr = 30'h3FF;
    q_a.push_back({1'b0, 32'hCAFE_F00D});
    tick();
    core_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      m_rdy = 1'($urandom_range(0, 1)); m_rdata = $urandom;
      chk("gd_asn_hi", m_asn, 1);
      chk("gd_no_ack", core_ack, 0);
      tick();
    end
    m_rdy = 1'b0; m_grntn = 1'b0; tick();
    chk("gd_asn", m_asn, 0);
    chk("gd_addr", m_addr, 30'h3FF);
    m_rdy = 1'b1; m_rdata = 32'hCAFE_F00D; tick();
    m_rdy = 1'b0; m_grntn = 1'b1;
    chk("gd_ack", core_ack, 1);
    tick();

    // TIMEOUT=8: ready on the final count wins, then a true timeout.
    to_run(1'b1);
    to_run(1'b0);

    // Back-to-back reads with core_req held, plus a pulse while busy.
    base = ack_cnt;
    core_req = 1'b1; core_rw = 1'b1; core_addr = 30'h10;
    q_a.push_back({1'b0, 32'h1111_1111});
    q_a.push_back({1'b0, 32'h2222_2222});
    tick();
    serve(32'h1111_1111, 0);
    chk("b2b_ack1", core_ack, 1);
    tick();
    chk("b2b_gap", m_reqn, 1);
    tick();
    chk("b2b_req2", m_reqn, 0);
    core_req = 1'b0; tick();
    core_req = 1'b1; tick();
    core_req = 1'b0;
    serve(32'h2222_2222, 1);
    chk("b2b_ack2", core_ack, 1);
    repeat (6) tick();
    chk("b2b_acks", ack_cnt - base, 2);
    chk("b2b_idle_reqn", m_reqn, 1);

    // Asynchronous reset during ACCESS, then normal recovery.
    core_req = 1'b1; core_rw = 1'b1; core_addr = 30'h77;
    tick();
    core_req = 1'b0; m_grntn = 1'b0; tick();
    chk("rst_mid_asn_lo", m_asn, 0);
    base = ack_cnt;
    #2 bus_rstn = 1'b0;
    #1;
    chk("rst_mid_outs", {m_asn, m_reqn, core_busy}, 3'b110);
    m_grntn = 1'b1;
    tick(); tick();
    #2 bus_rstn = 1'b1;
    repeat (4) tick();
    chk("rst_no_ack", ack_cnt - base, 0);
    core_req = 1'b1; core_rw = 1'b1; core_addr = 30'h78;
    q_a.push_back({1'b0, 32'h3333_3333});
    tick();
    core_req = 1'b0;
    serve(32'h3333_3333, 0);
    chk("rec_ack", core_ack, 1);
    repeat (3) tick();

    chk("q_a_empty", q_a.size(), 0);
    chk("q_b_empty", q_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
